op_issue_ctrl: RTL and testbench
================================

Name: op_issue_ctrl

Overview:
- Instruction-issue controller in front of the `cpu` datapath.
- Buffers incoming `operation` words in a FIFO and presents them to the cpu one at a time.
- Holds each op stable on the cpu `op` input until the cpu reports `done_out`, then inserts a NO_OP gap so the cpu stage-1 registers and micro-stage counter flush before the next op.
- Also provides a per-op watchdog, op counting and status to the host/sequencer side.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, >=2)
- TIMEOUT, 1023, max cycles an op may stay in BUSY before a watchdog error
- GAP_CYCLES, 2, NO_OP cycles driven after each completion (>=1)
- CNT_W, 16, width of the completed-op counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  host offers an op
- in_ready  out  1  FIFO can accept (= !full)
- in_op  in  operation  op word (mode, idx1_a, idx1_b, idx2_a, idx2_b, out_a, out_b)
- cpu_op  out  operation  registered op driven to cpu `op`
- cpu_done  in  1  cpu `done_out`
- busy  out  1  FIFO non-empty or state != IDLE
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- completed_cnt  out  CNT_W  ops completed since reset (wraps)
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, port `reset`. It clears everything on the next edge.
- Reset values: cpu_op.mode=NO_OP with all index fields 0; FIFO empty; state IDLE; counters 0; err_timeout 0; in_ready 1 (from the cycle after reset deasserts).
- Push: in_valid & in_ready writes in_op at the tail. No push when full.
- Pop: only in IDLE with count>0. Push and pop in the same cycle are both honoured; count is unchanged.
- No empty bypass: an op accepted at cycle t is popped at t+1 and appears on cpu_op at t+2.
- FSM states: IDLE, BUSY, GAP, ERR.
  - IDLE: cpu_op.mode=NO_OP. If count>0, pop the head.
    - Head mode NO_OP: discard it, stay IDLE, no count.
    - Otherwise: load cur_op, clear timer, go BUSY.
  - BUSY: cpu_op=cur_op, held stable every cycle. Timer increments each cycle.
    - cpu_done=1: completed_cnt+1, load gap counter with GAP_CYCLES-1, go GAP.
    - Else timer==TIMEOUT-1: set err_timeout, go ERR.
    - cpu_done and the timeout in the same cycle: completion wins.
  - GAP: cpu_op.mode=NO_OP. Gap counter decrements; at 0 go IDLE. cpu_done is ignored here, so trailing done pulses from the cpu pipeline are not counted.
  - ERR: cpu_op.mode=NO_OP. FIFO keeps accepting until full; no pops. Only reset exits.
- cpu_done is ignored in IDLE, GAP and ERR.
- completed_cnt wraps 2^CNT_W-1 -> 0.
- busy is combinational from state and count. fifo_count is registered.
- Reset mid-op (BUSY/GAP): the op is abandoned and FIFO contents are dropped. cpu_op is NO_OP from the next edge. The cpu shares the reset, so no partial write-back is tracked.
- Minimum per-op cost: 2 issue cycles + cpu latency + GAP_CYCLES. Back-to-back ops never overlap on cpu_op.

Decomposition:
- Add to the shared types header/package:
  - op_issue_state_e {IDLE, BUSY, GAP, ERR}
  - default constants OP_ISSUE_TIMEOUT=1023 and OP_ISSUE_GAP=2
- Reuse the existing `operation` and `op_e` types from that package.
- One sub-module: `op_fifo`, a parameterized synchronous FIFO of `operation` with push/pop/full/empty/count, read data registered at the head. The FSM, timer and counters stay in op_issue_ctrl.

Test Plan:
- Reset behaviour: after reset, with no input -> cpu_op.mode=NO_OP, busy=0, in_ready=1, fifo_count=0, completed_cnt=0.
- Single op: push one OP_CT_CT_ADD at t, cpu_done pulses at t+5 -> cpu_op equals the op over t+2..t+5; NO_OP over t+6..t+7; completed_cnt=1; busy=0 at t+8.
- Flow control and ordering: push 9 ops back-to-back with DEPTH=8 and cpu_done stuck low -> in_ready drops after the 8th accept (first op already popped, so 9 total accepted); ops issue in FIFO order.
- NO_OP filtering: queue ADD, NO_OP, OP_CT_PT_MUL -> the NO_OP is never presented; completed_cnt=2 after two done pulses. Extra done pulses during GAP are not counted.
- Watchdog: issue OP_CT_PT_MUL with cpu_done never asserted -> err_timeout=1 exactly TIMEOUT cycles after BUSY entry; cpu_op=NO_OP; subsequent pushes fill the FIFO but no pops occur; reset clears the error.
- Boundary cases:
  - cpu_done on the final timeout cycle -> completion, no error.
  - Reset asserted in BUSY with 3 ops queued -> fifo_count=0 and cpu_op=NO_OP next cycle.

Source files
------------

// File: rtl/op_issue_ctrl_pkg.sv
// Shared types for the cpu issue path: operation word, op modes and the
// issue-controller state encoding with its default timing constants.
package op_issue_ctrl_pkg;

    localparam int IDX_W = 4;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [2:0] {
        NO_OP        = 3'd0,
        OP_CT_CT_ADD = 3'd1,
        OP_CT_CT_MUL = 3'd2,
        OP_CT_PT_ADD = 3'd3,
        OP_CT_PT_MUL = 3'd4
    } op_e;

    typedef struct packed {
        op_e  mode;
        idx_t idx1_a;
        idx_t idx1_b;
        idx_t idx2_a;
        idx_t idx2_b;
        idx_t out_a;
        idx_t out_b;
    } operation;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2,
        ERR  = 2'd3
    } op_issue_state_e;

    localparam int OP_ISSUE_TIMEOUT = 1023;
    localparam int OP_ISSUE_GAP     = 2;

    // NO_OP with every index cleared: the idle value of the cpu op bus.
    function automatic operation nop_op();
        operation o;
        o      = '0;
        o.mode = NO_OP;
        return o;
    endfunction

endpackage

// File: rtl/op_issue_ctrl_fifo.sv
// Synchronous FIFO of operation words; the head entry is always visible on
// rd_data straight from the storage registers.
module op_fifo
    import op_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  operation                 wr_data,
    input  logic                     pop,
    output operation                 rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    operation          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/op_issue_ctrl.sv
// Issue controller for the cpu: queues host ops, holds each on cpu_op until
// done, then drives a NO_OP gap so the cpu pipeline flushes between ops.
module op_issue_ctrl
    import op_issue_ctrl_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = OP_ISSUE_TIMEOUT,
    parameter int GAP_CYCLES = OP_ISSUE_GAP,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    // Host side: an op transfers on a clock edge where in_valid && in_ready;
    // in_op must be held stable while in_valid is high and in_ready is low.
    input  logic                     in_valid,
    output logic                     in_ready,
    input  operation                 in_op,
    output operation                 cpu_op,
    input  logic                     cpu_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         completed_cnt,
    output logic                     err_timeout,
    output op_issue_state_e          state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    op_issue_state_e   state;
    op_issue_state_e   state_next;

    operation          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              pop_en;

    operation          cur_op;
    operation          cpu_op_next;
    logic [TW-1:0]     timer;
    logic [GW-1:0]     gap_cnt;
    logic              timer_last;
    logic              load_cur;
    logic              complete;
    logic              timeout_hit;

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && in_ready;
    assign timer_last = (timer == TW'(TIMEOUT - 1));
    assign busy       = (state != IDLE) || (fifo_count != '0);
    assign state_dbg  = state;

    op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (in_op),
        .pop     (pop_en),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty && head.mode != NO_OP) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // A done on the last allowed cycle still counts as completion.
                if (cpu_done) begin
                    state_next = GAP;
                end else if (timer_last) begin
                    state_next = ERR;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop_en      = 1'b0;
        load_cur    = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        cpu_op_next = nop_op();
        case (state)
            IDLE: begin
                pop_en   = !fifo_empty;
                load_cur = !fifo_empty && head.mode != NO_OP;
                if (load_cur) begin
                    cpu_op_next = head;
                end
            end
            BUSY: begin
                complete    = cpu_done;
                timeout_hit = !cpu_done && timer_last;
                if (!complete && !timeout_hit) begin
                    cpu_op_next = cur_op;
                end
            end
            default: begin
                cpu_op_next = nop_op();
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_op        <= nop_op();
            cpu_op        <= nop_op();
            timer         <= '0;
            gap_cnt       <= '0;
            completed_cnt <= '0;
            err_timeout   <= 1'b0;
        end else begin
            cpu_op <= cpu_op_next;

            if (load_cur) begin
                cur_op <= head;
                timer  <= '0;
            end else if (state == BUSY) begin
                timer <= timer + TW'(1);
            end

            // The gap counter counts down to zero; GAP lasts GAP_CYCLES cycles.
            if (complete) begin
                completed_cnt <= completed_cnt + CNT_W'(1);
                gap_cnt       <= GW'(GAP_CYCLES - 1);
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_op_issue_ctrl.sv
// Directed bench for op_issue_ctrl: ops pushed by the driver are queued as
// expected issues; a negedge monitor checks issue order and op hold stability.
module tb_op_issue_ctrl;
    import op_issue_ctrl_pkg::*;

    localparam int DEPTH      = 8;
    localparam int TIMEOUT    = 1023;
    localparam int GAP_CYCLES = 2;
    localparam int CNT_W      = 16;
    localparam int W          = $bits(operation);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    operation                in_op;
    operation                cpu_op;
    logic                    cpu_done;
    logic                    busy;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [CNT_W-1:0]        completed_cnt;
    logic                    err_timeout;
    op_issue_state_e         state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    operation prev_op;

    op_issue_ctrl #(
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .cpu_op        (cpu_op),
        .cpu_done      (cpu_done),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .completed_cnt (completed_cnt),
        .err_timeout   (err_timeout),
        .state_dbg     (state_dbg)
    );

    // Clock and global time limit
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    // Helpers and driver tasks
    function automatic operation mk(input op_e m, input int a);
        operation o;
        o.mode   = m;
        o.idx1_a = idx_t'(a);
        o.idx1_b = idx_t'(a + 1);
        o.idx2_a = idx_t'(a + 2);
        o.idx2_b = idx_t'(a + 3);
        o.out_a  = idx_t'(a + 4);
        o.out_b  = idx_t'(a + 5);
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input operation op);
        check("push_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        if (op.mode != NO_OP) begin
            exp_q.push_back(op);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_op(input string name);
        int n;
        n = 0;
        while (cpu_op.mode == NO_OP && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (cpu_op.mode == NO_OP) begin
            errors++;
            $display("FAIL %s: no op issued within %0d cycles", name, n);
        end
    endtask

    task automatic pulse_done(input int cycles);
        cpu_done = 1'b1;
        repeat (cycles) step();
        cpu_done = 1'b0;
    endtask

    // Scoreboard monitor: new presentations pop the expected queue, held ops must not change
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        if (reset) begin
            prev_op = nop_op();
        end else begin
            a = cpu_op;
            if (cpu_op.mode != NO_OP) begin
                checks++;
                if (prev_op.mode == NO_OP) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL issue_unexpected: got %0h expected none", a);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            errors++;
                            $display("FAIL issue_order: got %0h expected %0h", a, e);
                        end
                    end
                end else if (cpu_op !== prev_op) begin
                    errors++;
                    $display("FAIL issue_hold: got %0h expected %0h", a, W'(prev_op));
                end
            end
            prev_op = cpu_op;
        end
    end

    // Directed stimulus
    initial begin
        operation op_a;
        prev_op  = nop_op();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = nop_op();
        cpu_done = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        check("rst_cpu_op", 32'(cpu_op), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_completed", 32'(completed_cnt), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        // Single op: accepted at t, done at t+5
        op_a = mk(OP_CT_CT_ADD, 1);
        push(op_a);
        check("single_t1_nop", 32'(cpu_op.mode), 32'(NO_OP));
        check("single_t1_count", 32'(fifo_count), 32'd1);
        step();
        for (int i = 2; i <= 5; i++) begin
            check("single_hold", 32'(cpu_op), 32'(op_a));
            if (i == 5) cpu_done = 1'b1;
            step();
        end
        cpu_done = 1'b0;
        check("single_gap1", 32'(cpu_op.mode), 32'(NO_OP));
        check("single_cnt", 32'(completed_cnt), 32'd1);
        check("single_busy_gap", 32'(busy), 32'd1);
        step();
        check("single_gap2", 32'(cpu_op.mode), 32'(NO_OP));
        step();
        check("single_idle_busy", 32'(busy), 32'd0);

        // Flow control: nine back-to-back pushes with done held low
        for (int i = 0; i < 9; i++) begin
            push(mk((i % 2 == 0) ? OP_CT_CT_ADD : OP_CT_PT_MUL, i + 2));
        end
        check("flow_ready_low", 32'(in_ready), 32'd0);
        check("flow_count", 32'(fifo_count), 32'd8);
        in_valid = 1'b1;
        in_op    = mk(OP_CT_PT_ADD, 9);
        step();
        in_valid = 1'b0;
        check("flow_count_full", 32'(fifo_count), 32'd8);
        for (int i = 0; i < 9; i++) begin
            wait_op("flow_drain");
            pulse_done(1);
        end
        repeat (4) step();
        check("flow_completed", 32'(completed_cnt), 32'd10);
        check("flow_idle_busy", 32'(busy), 32'd0);

        // NO_OP filtering and trailing done pulses during GAP
        push(mk(OP_CT_CT_ADD, 3));
        push(mk(NO_OP, 7));
        push(mk(OP_CT_PT_MUL, 5));
        wait_op("filter_first");
        check("filter_first_mode", 32'(cpu_op.mode), 32'(OP_CT_CT_ADD));
        pulse_done(3);
        check("filter_cnt1", 32'(completed_cnt), 32'd11);
        wait_op("filter_second");
        check("filter_second_mode", 32'(cpu_op.mode), 32'(OP_CT_PT_MUL));
        pulse_done(1);
        repeat (4) step();
        check("filter_cnt2", 32'(completed_cnt), 32'd12);
        check("filter_empty", 32'(fifo_count), 32'd0);

        // Watchdog: no done for a full TIMEOUT window
        do_reset();
        check("wd_cnt_cleared", 32'(completed_cnt), 32'd0);
        push(mk(OP_CT_PT_MUL, 6));
        step();
        check("wd_busy_entry", 32'(cpu_op.mode), 32'(OP_CT_PT_MUL));
        repeat (TIMEOUT - 1) step();
        check("wd_before", 32'(err_timeout), 32'd0);
        check("wd_before_op", 32'(cpu_op.mode), 32'(OP_CT_PT_MUL));
        step();
        check("wd_err", 32'(err_timeout), 32'd1);
        check("wd_nop", 32'(cpu_op.mode), 32'(NO_OP));
        check("wd_no_count", 32'(completed_cnt), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            push(mk(OP_CT_CT_MUL, i));
        end
        step();
        check("wd_fill_count", 32'(fifo_count), 32'd8);
        check("wd_fill_ready", 32'(in_ready), 32'd0);
        check("wd_err_sticky", 32'(err_timeout), 32'd1);
        check("wd_err_nop", 32'(cpu_op.mode), 32'(NO_OP));
        do_reset();
        check("wd_reset_err", 32'(err_timeout), 32'd0);
        check("wd_reset_count", 32'(fifo_count), 32'd0);
        check("wd_reset_busy", 32'(busy), 32'd0);

        // Done on the final timeout cycle wins over the watchdog
        push(mk(OP_CT_CT_ADD, 8));
        step();
        repeat (TIMEOUT - 1) step();
        check("edge_still_busy", 32'(cpu_op.mode), 32'(OP_CT_CT_ADD));
        pulse_done(1);
        check("edge_no_err", 32'(err_timeout), 32'd0);
        check("edge_completed", 32'(completed_cnt), 32'd1);
        check("edge_gap_nop", 32'(cpu_op.mode), 32'(NO_OP));
        repeat (3) step();
        check("edge_idle", 32'(busy), 32'd0);

        // Reset while BUSY with three ops still queued
        for (int i = 0; i < 4; i++) begin
            push(mk(OP_CT_PT_ADD, i + 10));
        end
        check("midrst_queued", 32'(fifo_count), 32'd3);
        check("midrst_busy_op", 32'(cpu_op.mode), 32'(OP_CT_PT_ADD));
        reset = 1'b1;
        exp_q.delete();
        step();
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_cpu_op", 32'(cpu_op), 32'd0);
        reset = 1'b0;
        step();
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_idle", 32'(busy), 32'd0);
        check("midrst_cnt", 32'(completed_cnt), 32'd0);
        repeat (3) step();
        check("midrst_no_issue", 32'(cpu_op.mode), 32'(NO_OP));

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
